// File: rtl/diaosi_types_pkg.sv
// Shared defaults, counter types and helpers for the pipe_stage elastic buffer.
// The counters typed here are used only when PIPE_STAGE_PERF_EN is defined.
package diaosi_types_pkg;

    localparam int PIPE_STAGE_DEPTH_DEFAULT = 2;
    localparam int PIPE_STAGE_WIDTH_DEFAULT = 32;

    typedef logic [31:0] perf_cnt32_t;
    typedef logic [15:0] perf_cnt16_t;

    // Encoding is {push, pop}, so the handshake pair can be cast straight to it.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic perf_cnt32_t sat_inc32(input perf_cnt32_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic perf_cnt16_t sat_inc16(input perf_cnt16_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy, pointer and handshake control for pipe_stage.
// Holds no payload; the top owns the storage and the output mux.
module pipe_stage_ctrl
    import diaosi_types_pkg::*;
#(
    parameter int DEPTH = PIPE_STAGE_DEPTH_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          rd_en;
    op_e           op;

    // NOTE: ready/valid come from the count register only, so out_ready never
    // reaches in_ready combinationally and a full stage cannot bypass.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    // Flush wins over both handshakes; a push in the flush cycle is dropped.
    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = out_valid && out_ready && !flush;
    assign op    = op_e'({wr_en, rd_en});

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    count_q  <= count_q + 1'b1;
                end
                OP_POP: begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    count_q  <= count_q - 1'b1;
                end
                OP_BOTH: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/pipe_stage.sv
// DEPTH-entry in-order elastic buffer with 1-cycle latency and zeroed bubbles.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / flush_cnt counters.
module pipe_stage
    import diaosi_types_pkg::*;
#(
    parameter int WIDTH = PIPE_STAGE_WIDTH_DEFAULT,
    parameter int DEPTH = PIPE_STAGE_DEPTH_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output perf_cnt32_t             stall_cnt,
    output perf_cnt16_t             flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    pipe_stage_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // NOTE: payload storage is deliberately not reset; stale entries are never
    // observable because the output is forced to zero whenever count is zero.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

`ifdef PIPE_STAGE_PERF_EN
    perf_cnt32_t stall_q;
    perf_cnt16_t flush_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_valid && !out_ready) stall_q <= sat_inc32(stall_q);
            if (flush)                   flush_q <= sat_inc16(flush_q);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: DEPTH=2 and DEPTH=4 instances, vector
// table, directed corner sequences and a random run against a queue model.
module tb_pipe_stage;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_count;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] a_stall, b_stall;
    logic [15:0] a_flcnt, b_flcnt;
`endif

    pipe_stage #(.WIDTH(32), .DEPTH(2)) dut_a (
        .CLK(CLK), .nRST(nRST), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(a_stall), .flush_cnt(a_flcnt)
`endif
    );

    pipe_stage #(.WIDTH(32), .DEPTH(4)) dut_b (
        .CLK(CLK), .nRST(nRST), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(b_stall), .flush_cnt(b_flcnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_b(input logic iv, input logic ordy, input logic fl, input logic [31:0] d);
        b_in_valid  = iv;
        b_out_ready = ordy;
        b_flush     = fl;
        b_in_data   = d;
    endtask

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] data;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
        logic        exp_in_ready;
    } vec_t;

    vec_t vecs[11];

    int q[$];
    int got[$];
    int next_val;
    int cyc;
    bit m_push, m_pop;

    initial begin
        // Expected state after the edge, DEPTH=4, starting empty.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 32'h11, 3'd1, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 32'h11, 3'd2, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 32'h22, 3'd2, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h44, 1'b1, 32'h22, 3'd3, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 32'h22, 3'd4, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h66, 1'b1, 32'h33, 3'd3, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 3'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h77, 1'b0, 32'h0,  3'd0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  3'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h88, 1'b1, 32'h88, 3'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  3'd0, 1'b1};

        nRST = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        drive_b(0, 0, 0, 32'h0);

        // Reset state while nRST is still low.
        #3;
        check("rst_a_count", 64'(a_count), 0);
        check("rst_a_valid", 64'(a_out_valid), 0);
        check("rst_a_data", 64'(a_out_data), 0);
        check("rst_a_in_ready", 64'(a_in_ready), 1);
        check("rst_b_count", 64'(b_count), 0);
        check("rst_b_in_ready", 64'(b_in_ready), 1);
        #9 nRST = 1'b1;
        tick();

        // DEPTH=2 single push with out_ready high: visible one edge later.
        a_in_valid = 1; a_in_data = 32'hA5A5_0001; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        check("d2_valid", 64'(a_out_valid), 1);
        check("d2_data", 64'(a_out_data), 64'h0000_0000_A5A5_0001);
        check("d2_count", 64'(a_count), 1);
        tick();
        check("d2_drained", 64'(a_count), 0);

        // Vector table on DEPTH=4.
        for (int i = 0; i < 11; i++) begin
            drive_b(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].data);
            tick();
            check($sformatf("vec%0d_valid", i), 64'(b_out_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 64'(b_out_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_count", i), 64'(b_count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_in_ready", i), 64'(b_in_ready), 64'(vecs[i].exp_in_ready));
        end
        drive_b(0, 0, 0, 32'h0);

        // Fill to full with out_ready low; fifth push is refused.
        for (int i = 0; i < 5; i++) begin
            drive_b(1, 0, 0, 32'h100 + 32'(i));
            tick();
            if (i == 3) begin
                check("full_count", 64'(b_count), 4);
                check("full_in_ready", 64'(b_in_ready), 0);
            end
        end
        check("full_5th_count", 64'(b_count), 4);
        drive_b(0, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_data", i), 64'(b_out_data), 64'(32'h100 + 32'(i)));
            tick();
        end
        check("drain_count", 64'(b_count), 0);
        check("drain_valid", 64'(b_out_valid), 0);

        // Flush at count=3 with a simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive_b(1, 0, 0, 32'h201 + 32'(i));
            tick();
        end
        check("pre_flush_count", 64'(b_count), 3);
        drive_b(1, 1, 1, 32'h2FF);
        tick();
        check("flush_count", 64'(b_count), 0);
        check("flush_valid", 64'(b_out_valid), 0);
        check("flush_data", 64'(b_out_data), 0);
        check("flush_in_ready", 64'(b_in_ready), 1);
        drive_b(0, 1, 0, 32'h0);
        tick();
        check("flush_push_absent", 64'(b_count), 0);

        // Asynchronous reset between edges at count=2.
        drive_b(1, 0, 0, 32'h401); tick();
        drive_b(1, 0, 0, 32'h402); tick();
        check("prerst_count", 64'(b_count), 2);
        drive_b(0, 0, 0, 32'h0);
        #2 nRST = 1'b0;
        #1;
        check("arst_count", 64'(b_count), 0);
        check("arst_data", 64'(b_out_data), 0);
        check("arst_valid", 64'(b_out_valid), 0);
        check("arst_in_ready", 64'(b_in_ready), 1);
        #1 nRST = 1'b1;
        drive_b(1, 0, 0, 32'h403);
        tick();
        check("postrst_count", 64'(b_count), 1);
        check("postrst_data", 64'(b_out_data), 64'h403);
        drive_b(0, 1, 0, 32'h0);
        tick();
        check("postrst_empty", 64'(b_count), 0);

        // Random run: 1..10 through DEPTH=4 against a queue model.
        q.delete(); got.delete();
        next_val = 1;
        cyc = 0;
        while (got.size() < 10 && cyc < 400) begin
            b_in_valid  = (next_val <= 10) && ($urandom_range(0, 3) != 0);
            b_in_data   = next_val;
            b_out_ready = 1'($urandom_range(0, 1));
            b_flush     = 0;
            check("rnd_in_ready", 64'(b_in_ready), 64'(q.size() < 4));
            m_push = b_in_valid && (q.size() < 4);
            m_pop  = (q.size() > 0) && b_out_ready;
            if (m_pop) begin
                got.push_back(int'(b_out_data));
                void'(q.pop_front());
            end
            if (m_push) begin
                q.push_back(next_val);
                next_val++;
            end
            tick();
            check("rnd_count", 64'(b_count), 64'(q.size()));
            check("rnd_data", 64'(b_out_data), (q.size() > 0) ? 64'(q[0]) : 64'h0);
            cyc++;
        end
        check("rnd_received", 64'(got.size()), 10);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("rnd_order%0d", i), 64'(got[i]), 64'(i + 1));
        drive_b(0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        check("rnd_final_empty", 64'(b_count), 0);

`ifdef PIPE_STAGE_PERF_EN
        drive_b(0, 0, 0, 32'h0);
        #2 nRST = 1'b0;
        #1 nRST = 1'b1;
        check("perf_rst_stall", 64'(b_stall), 0);
        check("perf_rst_flush", 64'(b_flcnt), 0);
        drive_b(1, 0, 0, 32'h1); tick();
        drive_b(0, 0, 0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        drive_b(0, 1, 0, 32'h0); tick();
        drive_b(0, 0, 1, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        drive_b(0, 0, 0, 32'h0); tick();
        check("perf_stall", 64'(b_stall), 7);
        check("perf_flush", 64'(b_flcnt), 3);
        drive_b(1, 0, 0, 32'h2); tick();
        drive_b(0, 0, 0, 32'h0);
        force dut_b.stall_q = 32'hFFFF_FFFE;
        #1 release dut_b.stall_q;
        for (int i = 0; i < 3; i++) tick();
        check("perf_stall_sat", 64'(b_stall), 64'hFFFF_FFFF);
        drive_b(0, 1, 0, 32'h0); tick();
        drive_b(0, 0, 0, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..1024).
REQ-002 Parameter DEPTH, default 2, entry count; power of 2, 2..16.
REQ-003 CLK  input  1  Sole clock; all state updates on posedge.
REQ-004 nRST  input  1  One clock; reset is asynchronous and active-low.
REQ-005 flush  input  1  Synchronous kill of all held entries.
REQ-006 in_valid  input  1  Upstream presents in_data.
REQ-007 in_ready  output  1  Stage can accept an entry this cycle.
REQ-008 in_data  input  WIDTH  Upstream payload.
REQ-009 out_valid  output  1  Head entry valid.
REQ-010 out_ready  input  1  Downstream takes the head this cycle.
REQ-011 out_data  output  WIDTH  Head payload.
REQ-012 count  output  $clog2(DEPTH)+1  Current occupancy.
REQ-013 stall_cnt  output  32  Cycles with out_valid=1 and out_ready=0; present only with PIPE_STAGE_PERF_EN.
REQ-014 flush_cnt  output  16  Cycles with flush=1; present only with PIPE_STAGE_PERF_EN.

Function
REQ-015 The block SHALL be a DEPTH-entry in-order elastic buffer: push = in_valid&&in_ready, pop = out_valid&&out_ready.
REQ-016 in_ready SHALL equal (count<DEPTH) from registered state only; it SHALL have no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count!=0); out_data SHALL be the head entry, and all-zero whenever count=0 (bubble).
REQ-018 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on out_data after edge N when the stage was empty.
REQ-019 Push only: count+1, write pointer advances modulo DEPTH.
REQ-020 Pop only: count-1, read pointer advances modulo DEPTH.
REQ-021 Push and pop together: count unchanged, both pointers advance; legal at any occupancy where in_ready=1.
REQ-022 Full (count=DEPTH): in_ready=0 even if out_ready=1; no same-cycle bypass.
REQ-023 Empty: out_valid=0; out_ready is ignored; no pointer/count change from pop.
REQ-024 flush=1 SHALL take priority over push and pop: next state count=0, both pointers=0; a same-cycle push is discarded.
REQ-025 Entry order SHALL be preserved across pointer wrap-around at every DEPTH.
REQ-026 Stored payload SHALL not be cleared on pop or flush; only the zero-when-empty output rule applies.

Reset
REQ-027 On nRST=0, asynchronously: count=0, pointers=0, out_valid=0, out_data=0, in_ready=1.
REQ-028 Reset mid-transfer SHALL discard all entries; the first edge after release behaves as an empty stage.
REQ-029 With PIPE_STAGE_PERF_EN, stall_cnt and flush_cnt SHALL reset to 0; only reset clears them.

Configuration
REQ-030 Macro PIPE_STAGE_PERF_EN defined: stall_cnt and flush_cnt ports and counters exist, each incrementing by 1 per qualifying cycle and saturating at all-ones.
REQ-031 Macro PIPE_STAGE_PERF_EN undefined: neither port nor counter logic exists; all other behaviour identical.

Structure
REQ-032 diaosi_types_pkg SHALL hold PIPE_STAGE_DEPTH_DEFAULT (2), PIPE_STAGE_WIDTH_DEFAULT (32) and typedefs perf_cnt32_t, perf_cnt16_t.
REQ-033 Pointer/count/ready/valid logic SHALL live in sub-module pipe_stage_ctrl; storage and output mux stay in pipe_stage.

Verification
REQ-034 DEPTH=2, push 0xA5A5_0001 with out_ready=1 -> out_valid=1, out_data=0xA5A5_0001 one edge later, count=1.
REQ-035 DEPTH=4, out_ready=0, push 5 back-to-back -> count=4, in_ready=0 after 4th; 5th not accepted; drain yields 4 entries in order.
REQ-036 DEPTH=4, 10 entries 1..10 with random out_ready -> output sequence exactly 1..10 across wrap, no loss or duplicate.
REQ-037 count=3, flush=1 with in_valid=1 and out_ready=1 -> next edge count=0, out_valid=0, out_data=0, pushed entry absent.
REQ-038 count=2, nRST pulsed low between edges -> count=0, out_data=0 immediately; in_ready=1.
REQ-039 PIPE_STAGE_PERF_EN, out_valid=1 with out_ready=0 for 7 cycles, flush 3 cycles -> stall_cnt=7, flush_cnt=3; forced near-max value saturates at 0xFFFF_FFFF.
